clk_gate_seq: RTL and testbench

//  Per-branch enable sequencer for a glitch-free clock switch; one instance per source clock.
//  - Consumes the 2-stage synchronized select and the synchronized peer-enable status.
//  - Drives the gate enable for its own clock.
//  - Exports its own status for the peer branch to synchronize.
//  - Breaks before make: this branch enables only after the peer status is seen low.

---
 rtl/clk_gate_seq.sv | 178 +++++++++++++++++
 tb/tb_clk_gate_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/clk_gate_seq.sv
// clk_gate_seq: per-branch break-before-make enable sequencer for one source of a glitch-free clock switch.
// Optional WAIT-state watchdog driving timeout_o is built only when CLKSW_TIMEOUT_EN is defined.
module clk_gate_seq #(
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned DRAIN_CYCLES   = 2,
   parameter int unsigned CNT_W          = 4,
   parameter bit          PRIORITY       = 1'b0,
   parameter bit          RESET_ON       = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk_in,
   input  logic rst_i,
   input  logic sel_i,
   input  logic peer_en_i,
   output logic clk_en_o,
   output logic en_status_o,
   output logic busy_o,
   output logic timeout_o
);

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_WAIT   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_ON     = 3'd3,
      ST_DRAIN  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
   localparam state_t           RST_STATE   = RESET_ON ? ST_ON : ST_OFF;

   // Counters must hold the largest load value and both delays must be at least one cycle.
   if ((SETTLE_CYCLES == 32'd0) || (DRAIN_CYCLES == 32'd0) || (TIMEOUT_CYCLES == 32'd0) ||
       (SETTLE_CYCLES > (32'd2 ** CNT_W)) || (DRAIN_CYCLES > (32'd2 ** CNT_W))) begin : g_cfg_err
      $error("clk_gate_seq: illegal parameter combination");
   end

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             clk_en_r;
   logic             en_status_r;
   logic             busy_r;

   // Output decode {clk_en, en_status, busy}; status is raised as soon as the branch claims the switch.
   function automatic logic [2:0] decode(input state_t st);
      logic [2:0] res;
      case (st)
         ST_OFF:    res = 3'b000;
         ST_WAIT:   res = 3'b001;
         ST_SETTLE: res = 3'b011;
         ST_ON:     res = 3'b110;
         ST_DRAIN:  res = 3'b011;
         default:   res = 3'b000;
      endcase
      return res;
   endfunction

   // Sequencer FSM with outputs registered from the state being entered.
   always_ff @(posedge clk_in) begin
      if (rst_i) begin
         state_r                          <= RST_STATE;
         cnt_r                            <= CNT_ZERO;
         {clk_en_r, en_status_r, busy_r}  <= decode(RST_STATE);
      end else begin
         case (state_r)
            ST_OFF: begin
               if (sel_i && !peer_en_i) begin
                  state_r                         <= ST_SETTLE;
                  cnt_r                           <= SETTLE_LOAD;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_SETTLE);
               end else if (sel_i) begin
                  state_r                         <= ST_WAIT;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_WAIT);
               end else begin
                  state_r                         <= ST_OFF;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_OFF);
               end
            end
            ST_WAIT: begin
               if (!sel_i) begin
                  state_r                         <= ST_OFF;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_OFF);
               end else if (!peer_en_i) begin
                  state_r                         <= ST_SETTLE;
                  cnt_r                           <= SETTLE_LOAD;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_SETTLE);
               end else begin
                  state_r                         <= ST_WAIT;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_WAIT);
               end
            end
            ST_SETTLE: begin
               // The clock never ran here, so abandoning the claim needs no drain.
               if (!sel_i) begin
                  state_r                         <= ST_OFF;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_OFF);
               end else if (peer_en_i && !PRIORITY) begin
                  state_r                         <= ST_WAIT;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_WAIT);
               end else if (cnt_r == CNT_ZERO) begin
                  state_r                         <= ST_ON;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_ON);
               end else begin
                  state_r                         <= ST_SETTLE;
                  cnt_r                           <= cnt_r - CNT_ONE;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_SETTLE);
               end
            end
            ST_ON: begin
               if (!sel_i) begin
                  state_r                         <= ST_DRAIN;
                  cnt_r                           <= DRAIN_LOAD;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_DRAIN);
               end else begin
                  state_r                         <= ST_ON;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_ON);
               end
            end
            ST_DRAIN: begin
               // Status is held so the peer cannot enable while the gated clock may still be settling.
               if (cnt_r == CNT_ZERO) begin
                  state_r                         <= ST_OFF;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_OFF);
               end else begin
                  state_r                         <= ST_DRAIN;
                  cnt_r                           <= cnt_r - CNT_ONE;
                  {clk_en_r, en_status_r, busy_r} <= decode(ST_DRAIN);
               end
            end
            default: begin
               state_r                            <= RST_STATE;
               cnt_r                              <= CNT_ZERO;
               {clk_en_r, en_status_r, busy_r}    <= decode(RST_STATE);
            end
         endcase
      end
   end

   assign clk_en_o    = clk_en_r;
   assign en_status_o = en_status_r;
   assign busy_o      = busy_r;

`ifdef CLKSW_TIMEOUT_EN
   localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 32'd1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_ONE   = WD_W'(32'd1);

   logic [WD_W-1:0] wd_cnt_r;
   logic            timeout_r;

   // WAIT watchdog: counts cycles spent in WAIT, restarts on every entry, flag is sticky until reset.
   always_ff @(posedge clk_in) begin
      if (rst_i) begin
         wd_cnt_r  <= {WD_W{1'b0}};
         timeout_r <= 1'b0;
      end else if (state_r != ST_WAIT) begin
         wd_cnt_r  <= {WD_W{1'b0}};
      end else if (wd_cnt_r != WD_LIMIT) begin
         wd_cnt_r  <= wd_cnt_r + WD_ONE;
         if ((wd_cnt_r + WD_ONE) == WD_LIMIT) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end
      end else begin
         wd_cnt_r  <= wd_cnt_r;
      end
   end

   assign timeout_o = timeout_r;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_clk_gate_seq.sv
// Directed bench for clk_gate_seq: single-branch sequencing, reset behaviour and a cross-wired
// PRIORITY 1/0 pair; timeout expectations follow CLKSW_TIMEOUT_EN.
module tb_clk_gate_seq;

`ifdef CLKSW_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sel, peer;
   logic clk_en, en_status, busy, timeout;
   logic r_clk_en, r_status, r_busy, r_timeout;
   logic rst_p, sel_a, sel_b;
   logic en_a, st_a, busy_a, to_a;
   logic en_b, st_b, busy_b, to_b;

   clk_gate_seq #(.SETTLE_CYCLES(2), .DRAIN_CYCLES(2), .CNT_W(4), .PRIORITY(1'b0),
                  .RESET_ON(1'b0), .TIMEOUT_CYCLES(8)) dut (
      .clk_in(clk), .rst_i(rst), .sel_i(sel), .peer_en_i(peer),
      .clk_en_o(clk_en), .en_status_o(en_status), .busy_o(busy), .timeout_o(timeout));

   clk_gate_seq #(.RESET_ON(1'b1)) dut_on (
      .clk_in(clk), .rst_i(rst), .sel_i(1'b1), .peer_en_i(1'b0),
      .clk_en_o(r_clk_en), .en_status_o(r_status), .busy_o(r_busy), .timeout_o(r_timeout));

   clk_gate_seq #(.PRIORITY(1'b1)) dut_a (
      .clk_in(clk), .rst_i(rst_p), .sel_i(sel_a), .peer_en_i(st_b),
      .clk_en_o(en_a), .en_status_o(st_a), .busy_o(busy_a), .timeout_o(to_a));

   clk_gate_seq #(.PRIORITY(1'b0)) dut_b (
      .clk_in(clk), .rst_i(rst_p), .sel_i(sel_b), .peer_en_i(st_a),
      .clk_en_o(en_b), .en_status_o(st_b), .busy_o(busy_b), .timeout_o(to_b));

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic b_seen;
      rst = 1'b1; sel = 1'b0; peer = 1'b0;
      rst_p = 1'b1; sel_a = 1'b0; sel_b = 1'b0;
      tick(); tick();
      check("rst_clk_en", clk_en, 1'b0);
      check("rst_status", en_status, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rston_clk_en", r_clk_en, 1'b1);
      check("rston_status", r_status, 1'b1);
      check("rston_busy", r_busy, 1'b0);

      // Claim with peer low: status after edge 1, enable after edge 3
      rst = 1'b0; sel = 1'b1; peer = 1'b0;
      tick();
      check("t1_status_e1", en_status, 1'b1);
      check("t1_clk_e1", clk_en, 1'b0);
      check("t1_busy_e1", busy, 1'b1);
      tick();
      check("t1_clk_e2", clk_en, 1'b0);
      tick();
      check("t1_clk_e3", clk_en, 1'b1);
      check("t1_busy_e3", busy, 1'b0);

      // Release: enable drops at once, status two edges later
      tick(); tick();
      sel = 1'b0;
      tick();
      check("t2_clk_m", clk_en, 1'b0);
      check("t2_status_m", en_status, 1'b1);
      check("t2_busy_m", busy, 1'b1);
      tick();
      check("t2_status_m1", en_status, 1'b1);
      check("t2_busy_m1", busy, 1'b1);
      tick();
      check("t2_status_m2", en_status, 1'b0);
      check("t2_busy_m2", busy, 1'b0);

      // Peer busy: hold in WAIT, watchdog per build
      sel = 1'b1; peer = 1'b1;
      tick();
      check("t3_wait_status", en_status, 1'b0);
      check("t3_wait_busy", busy, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         tick();
         check("t3_wait_clk", clk_en, 1'b0);
         check("t3_timeout", timeout, (TO_EN && (i >= 8)) ? 1'b1 : 1'b0);
      end
      peer = 1'b0;
      tick();
      check("t3_settle_status", en_status, 1'b1);
      check("t3_settle_clk", clk_en, 1'b0);
      tick();
      check("t3_clk_p1", clk_en, 1'b0);
      tick();
      check("t3_clk_p2", clk_en, 1'b1);
      check("t3_timeout_sticky", timeout, TO_EN);
      peer = 1'b1;
      tick();
      check("t3_on_ignores_peer", clk_en, 1'b1);
      peer = 1'b0;

      // Reset during SETTLE and during DRAIN
      sel = 1'b0;
      tick(); tick(); tick();
      check("t5_off_status", en_status, 1'b0);
      sel = 1'b1;
      tick();
      check("t5_settle_status", en_status, 1'b1);
      rst = 1'b1;
      tick();
      check("t5_rs_clk", clk_en, 1'b0);
      check("t5_rs_status", en_status, 1'b0);
      check("t5_rs_busy", busy, 1'b0);
      check("t5_rs_timeout", timeout, 1'b0);
      rst = 1'b0;
      tick(); tick(); tick();
      check("t5_on_again", clk_en, 1'b1);
      sel = 1'b0;
      tick();
      check("t5_drain_busy", busy, 1'b1);
      check("t5_drain_status", en_status, 1'b1);
      rst = 1'b1;
      tick();
      check("t5_rd_status", en_status, 1'b0);
      check("t5_rd_busy", busy, 1'b0);
      check("t5_rd_clk", clk_en, 1'b0);
      rst = 1'b0;

      // Simultaneous claim by a cross-wired pair
      rst_p = 1'b0; sel_a = 1'b1; sel_b = 1'b1;
      tick();
      check("t4_both_claim_a", st_a, 1'b1);
      check("t4_both_claim_b", st_b, 1'b1);
      tick();
      check("t4_b_backs_off", st_b, 1'b0);
      check("t4_a_keeps", st_a, 1'b1);
      check("t4_a_not_yet", en_a, 1'b0);
      tick();
      check("t4_a_on", en_a, 1'b1);
      check("t4_b_off", en_b, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_excl_hold", en_a & en_b, 1'b0);
      end
      sel_a = 1'b0;
      b_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t4_excl_swap", en_a & en_b, 1'b0);
         if (en_b) b_seen = 1'b1;
      end
      check("t4_b_takes_over", b_seen, 1'b1);
      check("t4_a_stays_off", en_a, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
